// File: rtl/rps_match_ctrl.sv
// Best-of-N rock-paper-scissors match sequencer: hidden lock-in, judge, timed hold, match winner.
// Optional collect-phase forfeit timeout is enabled by defining RPS_TIMEOUT_EN.
module rps_match_ctrl #(
    parameter int WIN_TARGET     = 3,
    parameter int HOLD_CYCLES    = 100000000,
    parameter int SCORE_W        = 4,
    parameter int TIMEOUT_CYCLES = 500000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               new_match,
    input  logic               lock1,
    input  logic               lock2,
    input  logic [2:0]         in1,
    input  logic [2:0]         in2,
    output logic [2:0]         phase,
    output logic               locked1,
    output logic               locked2,
    output logic [2:0]         show1,
    output logic [2:0]         show2,
    output logic [2:0]         result,
    output logic [SCORE_W-1:0] score1,
    output logic [SCORE_W-1:0] score2,
    output logic [1:0]         winner,
    output logic               err1,
    output logic               err2
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_JUDGE   = 3'd2,
        S_HOLD    = 3'd3,
        S_OVER    = 3'd4
    } state_t;

    localparam logic [2:0] ROCK     = 3'b001;
    localparam logic [2:0] PAPER    = 3'b010;
    localparam logic [2:0] SCISSORS = 3'b100;
    localparam logic [2:0] RES_P1   = 3'b100;
    localparam logic [2:0] RES_DRAW = 3'b010;
    localparam logic [2:0] RES_P2   = 3'b001;

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [SCORE_W-1:0] SCORE_WIN = SCORE_W'(WIN_TARGET);

    if (WIN_TARGET < 1 || WIN_TARGET > (2**SCORE_W) - 1 || HOLD_CYCLES < 1 || TIMEOUT_CYCLES < 1)
    begin : g_bad_param
        $error("rps_match_ctrl: parameter out of range");
    end

    function automatic logic onehot3(input logic [2:0] v);
        return (v == ROCK) || (v == PAPER) || (v == SCISSORS);
    endfunction

    function automatic logic beats(input logic [2:0] a, input logic [2:0] b);
        return (a == ROCK && b == SCISSORS) || (a == SCISSORS && b == PAPER) ||
               (a == PAPER && b == ROCK);
    endfunction

    state_t             state_q;
    logic               locked1_q, locked2_q;
    logic [2:0]         choice1_q, choice2_q;
    logic [2:0]         show1_q, show2_q;
    logic [2:0]         result_q;
    logic [SCORE_W-1:0] score1_q, score2_q;
    logic [1:0]         winner_q;
    logic               err1_q, err2_q;
    logic [HOLD_W-1:0]  hold_q;

    // A lock is only considered while the player is still open in COLLECT.
    logic take1_d, take2_d, rej1_d, rej2_d;
    logic [2:0] judge_d;

    assign take1_d = (state_q == S_COLLECT) && lock1 && !locked1_q && onehot3(in1);
    assign take2_d = (state_q == S_COLLECT) && lock2 && !locked2_q && onehot3(in2);
    assign rej1_d  = (state_q == S_COLLECT) && lock1 && !locked1_q && !onehot3(in1);
    assign rej2_d  = (state_q == S_COLLECT) && lock2 && !locked2_q && !onehot3(in2);

    always_comb begin
        judge_d = RES_DRAW;
        if (beats(choice1_q, choice2_q)) judge_d = RES_P1;
        else if (beats(choice2_q, choice1_q)) judge_d = RES_P2;
    end

`ifdef RPS_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] to_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            locked1_q <= 1'b0;
            locked2_q <= 1'b0;
            choice1_q <= '0;
            choice2_q <= '0;
            show1_q   <= '0;
            show2_q   <= '0;
            result_q  <= '0;
            score1_q  <= '0;
            score2_q  <= '0;
            winner_q  <= '0;
            err1_q    <= 1'b0;
            err2_q    <= 1'b0;
            hold_q    <= '0;
`ifdef RPS_TIMEOUT_EN
            to_q      <= '0;
`endif
        end else begin
            err1_q <= 1'b0;
            err2_q <= 1'b0;
            if (new_match) begin
                state_q   <= S_COLLECT;
                locked1_q <= 1'b0;
                locked2_q <= 1'b0;
                choice1_q <= '0;
                choice2_q <= '0;
                show1_q   <= '0;
                show2_q   <= '0;
                result_q  <= '0;
                score1_q  <= '0;
                score2_q  <= '0;
                winner_q  <= '0;
                hold_q    <= '0;
`ifdef RPS_TIMEOUT_EN
                to_q      <= '0;
`endif
            end else begin
                case (state_q)
                    S_IDLE, S_OVER: ;
                    S_COLLECT: begin
                        if (take1_d) begin
                            choice1_q <= in1;
                            locked1_q <= 1'b1;
                        end
                        if (take2_d) begin
                            choice2_q <= in2;
                            locked2_q <= 1'b1;
                        end
                        err1_q <= rej1_d;
                        err2_q <= rej2_d;
                        if (locked1_q && locked2_q) begin
                            state_q <= S_JUDGE;
                        end
`ifdef RPS_TIMEOUT_EN
                        // A lock arriving on the last waiting cycle beats the forfeit.
                        else if (locked1_q ^ locked2_q) begin
                            if (to_q == TO_LAST && !take1_d && !take2_d) begin
                                if (locked1_q) begin
                                    result_q <= RES_P1;
                                    score1_q <= score1_q + SCORE_W'(1);
                                    show1_q  <= choice1_q;
                                end else begin
                                    result_q <= RES_P2;
                                    score2_q <= score2_q + SCORE_W'(1);
                                    show2_q  <= choice2_q;
                                end
                                state_q <= S_HOLD;
                                hold_q  <= '0;
                                to_q    <= '0;
                            end else begin
                                to_q <= to_q + TO_W'(1);
                            end
                        end
`endif
                    end
                    S_JUDGE: begin
                        result_q <= judge_d;
                        if (judge_d == RES_P1) score1_q <= score1_q + SCORE_W'(1);
                        if (judge_d == RES_P2) score2_q <= score2_q + SCORE_W'(1);
                        show1_q <= choice1_q;
                        show2_q <= choice2_q;
                        hold_q  <= '0;
                        state_q <= S_HOLD;
                    end
                    S_HOLD: begin
                        if (hold_q == HOLD_LAST) begin
                            locked1_q <= 1'b0;
                            locked2_q <= 1'b0;
                            choice1_q <= '0;
                            choice2_q <= '0;
                            result_q  <= '0;
                            show1_q   <= '0;
                            show2_q   <= '0;
                            hold_q    <= '0;
`ifdef RPS_TIMEOUT_EN
                            to_q      <= '0;
`endif
                            if (score1_q == SCORE_WIN) begin
                                winner_q <= 2'b01;
                                state_q  <= S_OVER;
                            end else if (score2_q == SCORE_WIN) begin
                                winner_q <= 2'b10;
                                state_q  <= S_OVER;
                            end else begin
                                state_q  <= S_COLLECT;
                            end
                        end else begin
                            hold_q <= hold_q + HOLD_W'(1);
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign phase   = state_q;
    assign locked1 = locked1_q;
    assign locked2 = locked2_q;
    assign show1   = show1_q;
    assign show2   = show2_q;
    assign result  = result_q;
    assign score1  = score1_q;
    assign score2  = score2_q;
    assign winner  = winner_q;
    assign err1    = err1_q;
    assign err2    = err2_q;

endmodule

// File: tb/tb_rps_match_ctrl.sv
// Table-driven bench for rps_match_ctrl (WIN_TARGET=2, HOLD_CYCLES=4, TIMEOUT_CYCLES=8).
module tb_rps_match_ctrl;

    localparam logic [2:0] R = 3'b001, P = 3'b010, S = 3'b100;
    localparam logic [2:0] W1 = 3'b100, DR = 3'b010, W2 = 3'b001;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       new_match = 1'b0, lock1 = 1'b0, lock2 = 1'b0;
    logic [2:0] in1 = '0, in2 = '0;
    logic [2:0] phase, show1, show2, result;
    logic       locked1, locked2, err1, err2;
    logic [3:0] score1, score2;
    logic [1:0] winner;
    logic [25:0] act;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    rps_match_ctrl #(
        .WIN_TARGET(2), .HOLD_CYCLES(4), .SCORE_W(4), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst(rst), .new_match(new_match), .lock1(lock1), .lock2(lock2),
        .in1(in1), .in2(in2), .phase(phase), .locked1(locked1), .locked2(locked2),
        .show1(show1), .show2(show2), .result(result), .score1(score1), .score2(score2),
        .winner(winner), .err1(err1), .err2(err2)
    );

    assign act = {phase, locked1, locked2, show1, show2, result, score1, score2, winner, err1, err2};

    typedef struct {
        logic        nm, l1, l2;
        logic [2:0]  i1, i2;
        logic [25:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [25:0] outs(input logic [2:0] ph, input logic k1, input logic k2,
                                         input logic [2:0] s1, input logic [2:0] s2,
                                         input logic [2:0] res, input logic [3:0] c1,
                                         input logic [3:0] c2, input logic [1:0] w,
                                         input logic e1, input logic e2);
        return {ph, k1, k2, s1, s2, res, c1, c2, w, e1, e2};
    endfunction

    task automatic add(input logic nm, input logic l1, input logic l2,
                       input logic [2:0] i1, input logic [2:0] i2, input logic [25:0] exp);
        vec_t v;
        v.nm = nm; v.l1 = l1; v.l2 = l2; v.i1 = i1; v.i2 = i2; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [25:0] got, input logic [25:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        // round 1: p1 rock vs p2 scissors, lock pulse in HOLD ignored
        add(1,0,0,0,0, outs(1,0,0,0,0,0,0,0,0,0,0));
        add(0,1,0,R,0, outs(1,1,0,0,0,0,0,0,0,0,0));
        add(0,0,0,0,0, outs(1,1,0,0,0,0,0,0,0,0,0));
        add(0,0,1,0,S, outs(1,1,1,0,0,0,0,0,0,0,0));
        add(0,0,0,0,0, outs(2,1,1,0,0,0,0,0,0,0,0));
        add(0,0,0,0,0, outs(3,1,1,R,S,W1,1,0,0,0,0));
        add(0,0,0,0,0, outs(3,1,1,R,S,W1,1,0,0,0,0));
        add(0,1,0,P,0, outs(3,1,1,R,S,W1,1,0,0,0,0));
        add(0,0,1,0,0, outs(3,1,1,R,S,W1,1,0,0,0,0));
        add(0,0,0,0,0, outs(1,0,0,0,0,0,1,0,0,0,0));
        // round 2: simultaneous paper/paper draw
        add(0,1,1,P,P, outs(1,1,1,0,0,0,1,0,0,0,0));
        add(0,0,0,0,0, outs(2,1,1,0,0,0,1,0,0,0,0));
        for (int k = 0; k < 4; k++) add(0,0,0,0,0, outs(3,1,1,P,P,DR,1,0,0,0,0));
        add(0,0,0,0,0, outs(1,0,0,0,0,0,1,0,0,0,0));
        // round 3: rejected locks, relock ignored, p2 rock beats p1 scissors
        add(0,1,0,3'b011,0, outs(1,0,0,0,0,0,1,0,0,1,0));
        add(0,0,0,0,0,      outs(1,0,0,0,0,0,1,0,0,0,0));
        add(0,1,0,3'b000,0, outs(1,0,0,0,0,0,1,0,0,1,0));
        add(0,1,0,S,0,      outs(1,1,0,0,0,0,1,0,0,0,0));
        add(0,1,0,R,0,      outs(1,1,0,0,0,0,1,0,0,0,0));
        add(0,0,1,0,R,      outs(1,1,1,0,0,0,1,0,0,0,0));
        add(0,0,0,0,0,      outs(2,1,1,0,0,0,1,0,0,0,0));
        for (int k = 0; k < 4; k++) add(0,0,0,0,0, outs(3,1,1,S,R,W2,1,1,0,0,0));
        add(0,0,0,0,0,      outs(1,0,0,0,0,0,1,1,0,0,0));
        // fresh match: p2 paper beats rock twice -> OVER
        add(1,0,0,0,0, outs(1,0,0,0,0,0,0,0,0,0,0));
        add(0,1,1,R,P, outs(1,1,1,0,0,0,0,0,0,0,0));
        add(0,0,0,0,0, outs(2,1,1,0,0,0,0,0,0,0,0));
        for (int k = 0; k < 4; k++) add(0,0,0,0,0, outs(3,1,1,R,P,W2,0,1,0,0,0));
        add(0,0,0,0,0, outs(1,0,0,0,0,0,0,1,0,0,0));
        add(0,1,1,R,P, outs(1,1,1,0,0,0,0,1,0,0,0));
        add(0,0,0,0,0, outs(2,1,1,0,0,0,0,1,0,0,0));
        for (int k = 0; k < 4; k++) add(0,0,0,0,0, outs(3,1,1,R,P,W2,0,2,0,0,0));
        add(0,0,0,0,0, outs(4,0,0,0,0,0,0,2,2'b10,0,0));
        add(0,1,1,R,P, outs(4,0,0,0,0,0,0,2,2'b10,0,0));
        add(0,1,0,0,0, outs(4,0,0,0,0,0,0,2,2'b10,0,0));
        add(1,0,0,0,0, outs(1,0,0,0,0,0,0,0,0,0,0));
        // new_match mid-collect drops the lock; err2 on multi-hot
        add(0,1,0,R,0,      outs(1,1,0,0,0,0,0,0,0,0,0));
        add(1,0,0,0,0,      outs(1,0,0,0,0,0,0,0,0,0,0));
        add(0,0,1,0,3'b110, outs(1,0,0,0,0,0,0,0,0,0,1));
        add(0,1,1,R,S,      outs(1,1,1,0,0,0,0,0,0,0,0));
        add(0,0,0,0,0,      outs(2,1,1,0,0,0,0,0,0,0,0));
        add(0,0,0,0,0,      outs(3,1,1,R,S,W1,1,0,0,0,0));

        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", act, '0);
        rst = 1'b1;
        tick();
        check("idle_after_release", act, '0);

        for (int i = 0; i < vecs.size(); i++) begin
            new_match = vecs[i].nm;
            lock1 = vecs[i].l1;
            lock2 = vecs[i].l2;
            in1 = vecs[i].i1;
            in2 = vecs[i].i2;
            tick();
            check($sformatf("row%0d", i), act, vecs[i].exp);
        end
        new_match = 1'b0; lock1 = 1'b0; lock2 = 1'b0; in1 = '0; in2 = '0;

        // asynchronous reset while in HOLD, no clock edge in between
        #1 rst = 1'b0;
        #1 check("async_reset_in_hold", act, '0);
        tick();
        tick();
        check("held_in_reset", act, '0);
        rst = 1'b1;
        lock1 = 1'b1; in1 = R; lock2 = 1'b1; in2 = P;
        tick();
        check("lock_in_idle_1", act, '0);
        lock1 = 1'b0; lock2 = 1'b0;
        tick();
        check("lock_in_idle_2", act, '0);

`ifdef RPS_TIMEOUT_EN
        new_match = 1'b1;
        tick();
        new_match = 1'b0;
        lock1 = 1'b1; in1 = R;
        tick();
        lock1 = 1'b0;
        check("to_locked", act, outs(1,1,0,0,0,0,0,0,0,0,0));
        for (int k = 1; k < 8; k++) begin
            tick();
            check($sformatf("to_wait%0d", k), act, outs(1,1,0,0,0,0,0,0,0,0,0));
        end
        tick();
        check("to_forfeit", act, outs(3,1,0,R,0,W1,1,0,0,0,0));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
